// File: rtl/exception_ctrl.sv
// exception_ctrl: prioritises per-instruction exceptions and interrupts, emits a one-cycle CP0 record
// and sequences the pipeline flush/redirect.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int FLUSH_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  output logic [5:0]  int_sync_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_badaddr_i,
  input  logic        excp_adel_if_i,
  input  logic        excp_ri_i,
  input  logic        excp_syscall_i,
  input  logic        excp_trap_i,
  input  logic        excp_ov_i,
  input  logic        excp_adel_i,
  input  logic        excp_ades_i,
  input  logic        excp_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] exception_type_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] badvaddr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic wr_st, wr_ca, wr_epc, ie, exl, int_pend, from_if, detect;
  logic [7:0] im, ip;
  logic [31:0] epc, code, bad;
  logic unused;
  assign unused = ^{cp0_status_i[31:16], cp0_status_i[7:2], cp0_cause_i[31:16], cp0_cause_i[7:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], int_i};
  assign int_sync_o = sync_q[SYNC_STAGES-1];
  // An mtc0 in WB overrides the CP0 copy; for Cause only the software IP bits are writable.
  always_comb begin
    wr_st = wb_cp0_we_i && wb_cp0_waddr_i == 5'd12;
    wr_ca = wb_cp0_we_i && wb_cp0_waddr_i == 5'd13;
    wr_epc = wb_cp0_we_i && wb_cp0_waddr_i == 5'd14;
    ie = wr_st ? wb_cp0_wdata_i[0] : cp0_status_i[0];
    exl = wr_st ? wb_cp0_wdata_i[1] : cp0_status_i[1];
    im = wr_st ? wb_cp0_wdata_i[15:8] : cp0_status_i[15:8];
    ip = {cp0_cause_i[15:10], wr_ca ? wb_cp0_wdata_i[9:8] : cp0_cause_i[9:8]};
    epc = wr_epc ? wb_cp0_wdata_i : cp0_epc_i;
    int_pend = mem_valid_i && ie && !exl && |(ip & im);
    from_if = mem_valid_i && !int_pend && excp_adel_if_i;
    code = !mem_valid_i   ? 32'h0 :
           int_pend       ? 32'h1 :
           excp_adel_if_i ? 32'h4 :
           excp_ri_i      ? 32'hA :
           excp_syscall_i ? 32'h8 :
           excp_trap_i    ? 32'hD :
           excp_ov_i      ? 32'hC :
           excp_adel_i    ? 32'h4 :
           excp_ades_i    ? 32'h5 :
           excp_eret_i    ? 32'hE : 32'h0;
    bad = from_if ? mem_pc_i : (code == 32'h4 || code == 32'h5) ? mem_badaddr_i : 32'h0;
    detect = state == IDLE && code != 32'h0;
    state_nx = state;
    if (state == IDLE && detect) state_nx = FLUSH;
    else if (state == FLUSH && cnt == '0) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      exception_type_o <= '0;
      current_inst_addr_o <= '0;
      is_in_delayslot_o <= 1'b0;
      badvaddr_o <= '0;
      new_pc_o <= '0;
    end else begin
      state <= state_nx;
      cnt <= detect ? CW'(FLUSH_CYCLES - 1) : (state == FLUSH && cnt != '0) ? cnt - 1'b1 : cnt;
      exception_type_o <= detect ? code : 32'h0;
      current_inst_addr_o <= detect ? mem_pc_i : 32'h0;
      is_in_delayslot_o <= detect && mem_in_delayslot_i;
      badvaddr_o <= detect ? bad : 32'h0;
      new_pc_o <= detect ? (code == 32'hE ? epc : EXC_VECTOR) :
                  (state == FLUSH && cnt == '0) ? 32'h0 : new_pc_o;
    end
  assign flush_o = state == FLUSH;
  assign busy_o = state == FLUSH;
endmodule
